// File: rtl/timing_align_unit.sv
// Receive-side timing: a 16-phase counter derives the sample/symbol clocks and strobes,
// and two strobe-gated delay lines align the matched-filter samples and transmitted symbols.
module timing_align_unit #(
  parameter int SAM_W     = 18,
  parameter int DATA_W    = 2,
  parameter int SYM_DEPTH = 256
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [1:0]               sam_delay,
  input  logic signed [SAM_W-1:0]  sam_in,
  input  logic [7:0]               data_delay,
  input  logic [DATA_W-1:0]        data_in,
  output logic [3:0]               clk_phase,
  output logic                     sam_clk,
  output logic                     sym_clk,
  output logic                     sam_clk_en,
  output logic                     sym_clk_en,
  output logic signed [SAM_W-1:0]  sam_out,
  output logic [DATA_W-1:0]        data_out
);

  logic [3:0]              r_phase;
  logic                    w_sam_en;
  logic                    w_sym_en;
  logic signed [SAM_W-1:0] r_sam [1:3];
  logic [DATA_W-1:0]       r_data [1:SYM_DEPTH-1];
  logic signed [SAM_W-1:0] w_sam_tap [0:3];
  logic [DATA_W-1:0]       w_data_tap [0:SYM_DEPTH-1];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_phase <= 4'd0;
    end else begin
      r_phase <= r_phase + 4'd1;
    end
  end

  // Strobes fire on the last clk of each sample / symbol period.
  assign w_sam_en = (r_phase[1:0] == 2'd3);
  assign w_sym_en = (r_phase == 4'd15);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 1; k <= 3; k++) begin
        r_sam[k] <= '0;
      end
    end else if (w_sam_en) begin
      r_sam[1] <= sam_in;
      for (int k = 2; k <= 3; k++) begin
        r_sam[k] <= r_sam[k-1];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 1; k < SYM_DEPTH; k++) begin
        r_data[k] <= '0;
      end
    end else if (w_sym_en) begin
      r_data[1] <= data_in;
      for (int k = 2; k < SYM_DEPTH; k++) begin
        r_data[k] <= r_data[k-1];
      end
    end
  end

  // Tap 0 is the live input so a zero delay select is a pure passthrough.
  always_comb begin
    w_sam_tap[0] = sam_in;
    for (int k = 1; k <= 3; k++) begin
      w_sam_tap[k] = r_sam[k];
    end
  end

  always_comb begin
    w_data_tap[0] = data_in;
    for (int k = 1; k < SYM_DEPTH; k++) begin
      w_data_tap[k] = r_data[k];
    end
  end

  assign clk_phase  = r_phase;
  assign sam_clk    = r_phase[1];
  assign sym_clk    = r_phase[3];
  assign sam_clk_en = w_sam_en;
  assign sym_clk_en = w_sym_en;
  assign sam_out    = w_sam_tap[sam_delay];
  assign data_out   = w_data_tap[data_delay];

endmodule

// File: tb/tb_timing_align_unit.sv
// Directed/randomized bench for timing_align_unit against a cycle-count and
// strobe-history reference model.
module tb_timing_align_unit;
  localparam int SAM_W     = 18;
  localparam int DATA_W    = 2;
  localparam int SYM_DEPTH = 256;

  logic                    clk = 1'b0;
  logic                    reset;
  logic [1:0]              sam_delay;
  logic signed [SAM_W-1:0] sam_in;
  logic [7:0]              data_delay;
  logic [DATA_W-1:0]       data_in;
  logic [3:0]              clk_phase;
  logic                    sam_clk;
  logic                    sym_clk;
  logic                    sam_clk_en;
  logic                    sym_clk_en;
  logic signed [SAM_W-1:0] sam_out;
  logic [DATA_W-1:0]       data_out;

  int checks   = 0;
  int failures = 0;

  // Model: edges since release, plus histories of strobe-captured inputs (newest first).
  int                      cyc;
  logic signed [SAM_W-1:0] sam_hist[$];
  logic [DATA_W-1:0]       data_hist[$];
  int                      ramp_val;
  logic [6:0]              lfsr;

  timing_align_unit #(.SAM_W(SAM_W), .DATA_W(DATA_W), .SYM_DEPTH(SYM_DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .sam_delay  (sam_delay),
    .sam_in     (sam_in),
    .data_delay (data_delay),
    .data_in    (data_in),
    .clk_phase  (clk_phase),
    .sam_clk    (sam_clk),
    .sym_clk    (sym_clk),
    .sam_clk_en (sam_clk_en),
    .sym_clk_en (sym_clk_en),
    .sam_out    (sam_out),
    .data_out   (data_out)
  );

  always #5 clk = ~clk;

  function automatic void model_clear();
    cyc = 0;
    sam_hist.delete();
    data_hist.delete();
  endfunction

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic signed [SAM_W-1:0] exp_sam();
    int d = int'(sam_delay);
    if (d == 0) return sam_in;
    if (sam_hist.size() >= d) return sam_hist[d-1];
    return '0;
  endfunction

  function automatic logic [DATA_W-1:0] exp_data();
    int d = int'(data_delay);
    if (d == 0) return data_in;
    if (data_hist.size() >= d) return data_hist[d-1];
    return '0;
  endfunction

  task automatic check_outputs();
    int ph = cyc % 16;
    chk("clk_phase",  clk_phase, ph);
    chk("sam_clk",    sam_clk, (ph / 2) % 2);
    chk("sym_clk",    sym_clk, (ph / 8) % 2);
    chk("sam_clk_en", sam_clk_en, (ph % 4 == 3) ? 1 : 0);
    chk("sym_clk_en", sym_clk_en, (ph == 15) ? 1 : 0);
    chk("sam_out",    sam_out, exp_sam());
    chk("data_out",   data_out, exp_data());
  endtask

  // Inputs are set by the caller just after a falling edge; check, then advance one clk.
  task automatic cycle();
    #1;
    check_outputs();
    @(posedge clk);
    if (reset) begin
      if (cyc % 4 == 3) begin
        sam_hist.push_front(sam_in);
        if (sam_hist.size() > 3) void'(sam_hist.pop_back());
      end
      if (cyc % 16 == 15) begin
        data_hist.push_front(data_in);
        if (data_hist.size() > SYM_DEPTH - 1) void'(data_hist.pop_back());
      end
      cyc++;
    end
    @(negedge clk);
  endtask

  // Meaningful values on strobe cycles, random junk in between.
  task automatic run(input int n, input bit rand_dly);
    for (int i = 0; i < n; i++) begin
      if (rand_dly) begin
        sam_delay  = 2'($urandom_range(0, 3));
        data_delay = 8'($urandom_range(0, 255));
      end
      if (cyc % 4 == 3) begin
        sam_in   = SAM_W'(ramp_val);
        ramp_val = ramp_val + 1;
      end else begin
        sam_in = SAM_W'($urandom);
      end
      if (cyc % 16 == 15) begin
        lfsr    = {lfsr[5:0], lfsr[6] ^ lfsr[5]};
        data_in = lfsr[1:0];
      end else begin
        data_in = DATA_W'($urandom);
      end
      cycle();
    end
  endtask

  task automatic do_reset(input int n);
    reset = 1'b0;
    model_clear();
    for (int i = 0; i < n; i++) cycle();
    reset = 1'b1;
  endtask

  initial begin
    reset      = 1'b0;
    sam_delay  = 2'd3;
    data_delay = 8'd5;
    sam_in     = SAM_W'(123);
    data_in    = 2'd3;
    ramp_val   = -5;
    lfsr       = 7'h5a;
    model_clear();
    for (int i = 0; i < 3; i++) cycle();
    reset = 1'b1;

    // Phase counter and strobes
    run(40, 1'b0);

    // Sample delay sweep, ramp restarting at -5 for each delay
    for (int d = 0; d < 4; d++) begin
      sam_delay = 2'(d);
      ramp_val  = -5;
      run(40, 1'b0);
    end

    // Data delay 38 from empty lines, then 255 at the far end of the line
    do_reset(2);
    data_delay = 8'd38;
    sam_delay  = 2'd1;
    run(16 * 50, 1'b0);
    data_delay = 8'd0;
    run(48, 1'b0);
    data_delay = 8'd255;
    run(16 * 215, 1'b0);
    chk("hist_full", data_hist.size(), SYM_DEPTH - 1);

    // Delay selects changing every cycle
    run(16 * 40, 1'b1);

    // Mid-run reset at phase 9 with full lines
    sam_delay  = 2'd3;
    data_delay = 8'd200;
    for (int i = 0; i < 16 && (cyc % 16 != 9); i++) run(1, 1'b0);
    chk("reset_at_phase9", cyc % 16, 9);
    do_reset(3);
    run(1, 1'b0);
    chk("restart_phase1", clk_phase, 1);
    run(16 * 20, 1'b0);
    data_delay = 8'd10;
    run(16 * 4, 1'b0);

    // Live sample delay change between strobes
    sam_delay = 2'd2;
    for (int i = 0; i < 16 && (cyc % 16 != 5); i++) run(1, 1'b0);
    sam_delay = 2'd0;
    sam_in    = SAM_W'(-77);
    #1;
    chk("live_sam_change", sam_out, -77);
    cycle();
    run(32, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
